medidor_faixa_uc: RTL
=====================

// Module: medidor_faixa_uc
// PURPOSE
//  Control unit (Moore FSM) that sequences the range-meter datapath: periodic HC-SR04 measurement,
//  serial TX of each reading as "CDU#" (3 BCD digits + hash), and the "AAA#" hit message once the
//  target has stayed in range long enough (fim_3sec). Sits beside the datapath in the top level;
//  every datapath control strobe comes from here. Adds a measurement watchdog the datapath lacks.
// PARAMETERS
//  TIMEOUT_MEDIDA  1_500_000  clocks to wait for pronto_medida after mensurar (30 ms @ 50 MHz)
//  TW              21         width of watchdog counter; must hold TIMEOUT_MEDIDA
// PORTS
//  clock             in   1  system clock, all logic on rising edge
//  reset             in   1  synchronous, active-high; forces INICIAL
//  ligar             in   1  level; 1 = run, 0 = return to INICIAL from any state
//  pronto_medida     in   1  1-cycle pulse, ultrasonic interface has a new measurement
//  pronto_tx         in   1  1-cycle pulse, 7E1 transmitter finished a character
//  is_ultimo_char    in   1  measurement char counter at '#' (index 3)
//  is_ultimo_char_a  in   1  hit-message char counter at '#' (index 3)
//  fim_time          in   1  inter-measurement interval counter expired
//  fim_3sec          in   1  in-range hold counter expired (latched in datapath)
//  zera              out  1  datapath clear (all counters, registers, hit flag)
//  zera_time         out  1  sync clear of interval counter
//  conta_time        out  1  interval counter enable
//  mensurar          out  1  start one measurement
//  partida_tx        out  1  start TX of currently selected char
//  zera_char         out  1  sync clear of measurement char counter
//  conta_prox_char   out  1  advance measurement char counter
//  zera_char_a       out  1  sync clear of hit char counter
//  conta_prox_char_a out  1  advance hit char counter
//  registra_acertou  out  1  set hit flag (switches TX mux to hit message)
//  pronto            out  1  hit message fully sent; held in ACERTOU
//  timeout           out  1  sticky: a measurement timed out since last PREPARA
//  db_estado         out  4  current state code
// BEHAVIOUR
//  - All outputs except timeout are pure decodes of state (Moore); each strobe is 1 cycle/state visit.
//  - Reset (sync, priority over all): state=INICIAL(0), watchdog=0, timeout=0; all outputs 0.
//  - ligar=0 in any state other than INICIAL -> INICIAL next cycle (abort; no strobes in abort cycle).
//  - States / codes / asserted outputs / transitions:
//    0 INICIAL   none; ligar -> PREPARA
//    1 PREPARA   zera,zera_time,zera_char,zera_char_a; clears timeout -> ESPERA
//    2 ESPERA    conta_time; fim_3sec -> REG_AC (priority); else fim_time -> MEDE; else stay
//    3 MEDE      mensurar, zera_time; watchdog<=0 -> AG_MED
//    4 AG_MED    watchdog++; pronto_medida -> TX (wins if same cycle as timeout);
//                watchdog==TIMEOUT_MEDIDA-1 -> FIM_CIC, timeout<=1
//    5 TX        partida_tx -> ESP_TX
//    6 ESP_TX    pronto_tx & is_ultimo_char -> FIM_CIC; pronto_tx & !is_ultimo_char -> PROX
//    7 PROX      conta_prox_char -> TX
//    8 FIM_CIC   zera_char, zera_time -> ESPERA
//    9 REG_AC    registra_acertou, zera_char_a -> TX_A
//   10 TX_A      partida_tx -> ESP_TX_A
//   11 ESP_TX_A  pronto_tx & is_ultimo_char_a -> ACERTOU; pronto_tx & !last -> PROX_A
//   12 PROX_A    conta_prox_char_a -> TX_A
//   13 ACERTOU   pronto; stays until ligar=0 (-> INICIAL)
//   14,15        unused; -> INICIAL
//  - Exactly 4 partida_tx per measurement cycle and 4 per hit message; never two without pronto_tx between.
//  - pronto_tx outside ESP_TX/ESP_TX_A ignored; pronto_medida outside AG_MED ignored.
//  - fim_3sec only sampled in ESPERA: an in-progress CDU# frame always completes first.
//  - Watchdog saturates; no wrap. timeout is a registered flag, not state-decoded.
// TESTING
//  1 reset=1 3 cycles, ligar=1 -> db_estado=0, all strobes 0, timeout=0; release -> 0,1,2.
//  2 ligar=1, fim_time pulse, pronto_medida 10 cycles after mensurar, pronto_tx 20 cycles after each
//    partida_tx, is_ultimo_char on 4th -> exactly 4 partida_tx, 3 conta_prox_char, back to ESPERA(2).
//  3 fim_3sec=1 while in ESP_TX of char 2 -> frame finishes (4 chars), then REG_AC, 4 hit chars,
//    ACERTOU(13) with pronto=1 held; ligar=0 -> INICIAL, pronto=0.
//  4 TIMEOUT_MEDIDA=16, no pronto_medida -> FIM_CIC exactly 16 cycles after entering AG_MED,
//    timeout=1, no partida_tx; next PREPARA clears timeout.
//  5 pronto_medida on same cycle as watchdog expiry -> TX(5), timeout stays 0.
//  6 ligar=0 mid ESP_TX and reset=1 mid AG_MED -> INICIAL next cycle, no further strobes.

Source files
------------

// File: rtl/medidor_faixa_uc.sv
// Control unit (Moore FSM) for the range-meter datapath: periodic measurement, "CDU#" transmission,
// the "AAA#" hit message, and a watchdog that flags measurements that never complete.
module medidor_faixa_uc #(
  parameter int unsigned TIMEOUT_MEDIDA = 1_500_000,
  parameter int unsigned TW             = 21
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       pronto_medida,
  input  logic       pronto_tx,
  input  logic       is_ultimo_char,
  input  logic       is_ultimo_char_a,
  input  logic       fim_time,
  input  logic       fim_3sec,
  output logic       zera,
  output logic       zera_time,
  output logic       conta_time,
  output logic       mensurar,
  output logic       partida_tx,
  output logic       zera_char,
  output logic       conta_prox_char,
  output logic       zera_char_a,
  output logic       conta_prox_char_a,
  output logic       registra_acertou,
  output logic       pronto,
  output logic       timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL   = 4'd0,
    PREPARA   = 4'd1,
    ESPERA    = 4'd2,
    MEDE      = 4'd3,
    AG_MED    = 4'd4,
    TX        = 4'd5,
    ESP_TX    = 4'd6,
    PROX      = 4'd7,
    FIM_CIC   = 4'd8,
    REG_AC    = 4'd9,
    TX_A      = 4'd10,
    ESP_TX_A  = 4'd11,
    PROX_A    = 4'd12,
    ACERTOU   = 4'd13,
    LIVRE_14  = 4'd14,
    LIVRE_15  = 4'd15
  } estado_t;

  localparam logic [TW-1:0] WD_LIMITE = TW'(TIMEOUT_MEDIDA - 1);

  estado_t         estado;
  estado_t         proximo;
  logic [TW-1:0]   watchdog;
  logic            wd_expira;

  assign wd_expira = (watchdog == WD_LIMITE);

  always_ff @(posedge clock) begin
    if (reset) begin
      estado   <= INICIAL;
      watchdog <= '0;
      timeout  <= 1'b0;
    end else begin
      estado <= proximo;

      if (estado == MEDE) begin
        watchdog <= '0;
      end else if (estado == AG_MED && watchdog != '1) begin
        watchdog <= watchdog + 1'b1;
      end

      // a measurement that arrives on the expiry cycle is still accepted, so no flag then
      if (estado == PREPARA) begin
        timeout <= 1'b0;
      end else if (estado == AG_MED && ligar && !pronto_medida && wd_expira) begin
        timeout <= 1'b1;
      end
    end
  end

  always_comb begin
    proximo = estado;
    if (estado != INICIAL && !ligar) begin
      proximo = INICIAL;
    end else begin
      case (estado)
        INICIAL:  if (ligar) proximo = PREPARA;
        PREPARA:  proximo = ESPERA;
        ESPERA: begin
          if (fim_3sec)      proximo = REG_AC;
          else if (fim_time) proximo = MEDE;
        end
        MEDE:     proximo = AG_MED;
        AG_MED: begin
          if (pronto_medida)  proximo = TX;
          else if (wd_expira) proximo = FIM_CIC;
        end
        TX:       proximo = ESP_TX;
        ESP_TX: begin
          if (pronto_tx) proximo = is_ultimo_char ? FIM_CIC : PROX;
        end
        PROX:     proximo = TX;
        FIM_CIC:  proximo = ESPERA;
        REG_AC:   proximo = TX_A;
        TX_A:     proximo = ESP_TX_A;
        ESP_TX_A: begin
          if (pronto_tx) proximo = is_ultimo_char_a ? ACERTOU : PROX_A;
        end
        PROX_A:   proximo = TX_A;
        ACERTOU:  proximo = ACERTOU;
        default:  proximo = INICIAL;
      endcase
    end
  end

  always_comb begin
    zera              = 1'b0;
    zera_time         = 1'b0;
    conta_time        = 1'b0;
    mensurar          = 1'b0;
    partida_tx        = 1'b0;
    zera_char         = 1'b0;
    conta_prox_char   = 1'b0;
    zera_char_a       = 1'b0;
    conta_prox_char_a = 1'b0;
    registra_acertou  = 1'b0;
    pronto            = 1'b0;
    case (estado)
      PREPARA: begin
        zera        = 1'b1;
        zera_time   = 1'b1;
        zera_char   = 1'b1;
        zera_char_a = 1'b1;
      end
      ESPERA:   conta_time = 1'b1;
      MEDE: begin
        mensurar  = 1'b1;
        zera_time = 1'b1;
      end
      TX:       partida_tx = 1'b1;
      PROX:     conta_prox_char = 1'b1;
      FIM_CIC: begin
        zera_char = 1'b1;
        zera_time = 1'b1;
      end
      REG_AC: begin
        registra_acertou = 1'b1;
        zera_char_a      = 1'b1;
      end
      TX_A:     partida_tx = 1'b1;
      PROX_A:   conta_prox_char_a = 1'b1;
      ACERTOU:  pronto = 1'b1;
      default: ;
    endcase
  end

  assign db_estado = estado;

endmodule
